// File: rtl/midori_rc_sequencer.sv
// Midori64 round-constant sequencer: walks rounds 0..14 forward or 14..0 in reverse,
// holding each round for CYCLES_PER_ROUND cycles, and expands the constant into a key-XOR mask.

module MUX_RC (
  input  logic [3:0]  sel_i,
  output logic [15:0] rc_o
);

  // Midori64 round constants; element 0 of each 4x4 constant sits in the MSB
  always_comb begin
    rc_o = 16'h0000;
    case (sel_i)
      4'd0:    rc_o = 16'h15B3;
      4'd1:    rc_o = 16'h78C0;
      4'd2:    rc_o = 16'hA435;
      4'd3:    rc_o = 16'h6213;
      4'd4:    rc_o = 16'h104F;
      4'd5:    rc_o = 16'hD170;
      4'd6:    rc_o = 16'h0266;
      4'd7:    rc_o = 16'h0BCC;
      4'd8:    rc_o = 16'h9481;
      4'd9:    rc_o = 16'h40B8;
      4'd10:   rc_o = 16'h7197;
      4'd11:   rc_o = 16'h228E;
      4'd12:   rc_o = 16'h5130;
      4'd13:   rc_o = 16'hF8CA;
      4'd14:   rc_o = 16'hDF90;
      default: rc_o = 16'h0000;
    endcase
  end

endmodule

module midori_rc_sequencer #(
  parameter int CYCLES_PER_ROUND = 4,
  parameter int CW = ($clog2(CYCLES_PER_ROUND) > 0) ? $clog2(CYCLES_PER_ROUND) : 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dec,
  input  logic        stall,
  input  logic        abort,
  output logic        busy,
  output logic        rc_valid,
  output logic [3:0]  round_idx,
  output logic [15:0] round_cnst,
  output logic [63:0] rc_mask,
  output logic        first_round,
  output logic        last_round,
  output logic        round_step,
  output logic        done
);

  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    RUN      = 1'b1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_ROUND - 1);
  localparam logic [3:0]    IDX_MAX  = 4'd14;

  logic [0:0]    state_q, state_d;
  logic          dir_q, dir_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          done_q, done_d;
  logic          cycEnd, idxFirst, idxLast;
  logic [15:0]   rcRaw;

  assign cycEnd   = (cyc_q == CYC_LAST);
  assign idxFirst = dir_q ? (idx_q == IDX_MAX) : (idx_q == 4'd0);
  assign idxLast  = dir_q ? (idx_q == 4'd0) : (idx_q == IDX_MAX);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          dir_d   = dec;
          idx_d   = dec ? IDX_MAX : 4'd0;
          cyc_d   = '0;
        end
      end
      RUN: begin
        // abort outranks stall; a stalled cycle simply leaves every register alone
        if (abort) begin
          state_d = IDLE;
          idx_d   = 4'd0;
          cyc_d   = '0;
        end else if (!stall) begin
          if (!cycEnd) begin
            cyc_d = cyc_q + 1'b1;
          end else if (idxLast) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            cyc_d   = '0;
            done_d  = 1'b1;
          end else begin
            cyc_d = '0;
            idx_d = dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      idx_q   <= 4'd0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
    end
  end

  MUX_RC uMuxRc (
    .sel_i (idx_q),
    .rc_o  (rcRaw)
  );

  assign busy        = (state_q == RUN);
  assign rc_valid    = busy;
  assign round_idx   = idx_q;
  assign round_cnst  = busy ? rcRaw : 16'h0000;
  assign first_round = busy && idxFirst;
  assign last_round  = busy && idxLast;
  assign round_step  = busy && cycEnd && !stall;
  assign done        = done_q;

  // each constant bit lands on the LSB of its 4-bit cell
  always_comb begin
    rc_mask = '0;
    for (int j = 0; j < 16; j++) begin
      rc_mask[4*j] = round_cnst[j];
    end
  end

endmodule

// File: tb/tb_midori_rc_sequencer.sv
// Scoreboard bench for midori_rc_sequencer: randomized runs on a CPR=4 instance checked
// by a round-level reference queue, plus directed runs on a CPR=1 instance.

module tb_midori_rc_sequencer;

  localparam int CPR    = 4;
  localparam int ROUNDS = 15;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] cnst;
    logic        first;
    logic        last;
  } roundExp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, dec = 1'b0, stall = 1'b0, abort = 1'b0;
  logic        busy, rc_valid, first_round, last_round, round_step, done;
  logic [3:0]  round_idx;
  logic [15:0] round_cnst;
  logic [63:0] rc_mask;

  logic        start1 = 1'b0, dec1 = 1'b0, stall1 = 1'b0, abort1 = 1'b0;
  logic        busy1, valid1, first1, last1, step1, done1;
  logic [3:0]  idx1;
  logic [15:0] cnst1;
  logic [63:0] mask1;

  int        testCount = 0;
  int        failCount = 0;
  int        pendingDone = 0;
  bit        monEnable = 1'b0;
  roundExp_t roundQ[$];

  midori_rc_sequencer #(.CYCLES_PER_ROUND(CPR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dec(dec), .stall(stall), .abort(abort),
    .busy(busy), .rc_valid(rc_valid), .round_idx(round_idx), .round_cnst(round_cnst),
    .rc_mask(rc_mask), .first_round(first_round), .last_round(last_round),
    .round_step(round_step), .done(done)
  );

  midori_rc_sequencer #(.CYCLES_PER_ROUND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dec(dec1), .stall(stall1), .abort(abort1),
    .busy(busy1), .rc_valid(valid1), .round_idx(idx1), .round_cnst(cnst1),
    .rc_mask(mask1), .first_round(first1), .last_round(last1),
    .round_step(step1), .done(done1)
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Midori64 round constants as published
  function automatic logic [15:0] rcOf(input int r);
    case (r)
      0: return 16'h15B3;   1: return 16'h78C0;   2: return 16'hA435;
      3: return 16'h6213;   4: return 16'h104F;   5: return 16'hD170;
      6: return 16'h0266;   7: return 16'h0BCC;   8: return 16'h9481;
      9: return 16'h40B8;  10: return 16'h7197;  11: return 16'h228E;
      12: return 16'h5130; 13: return 16'hF8CA;  14: return 16'hDF90;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [63:0] expandMask(input logic [15:0] c);
    logic [63:0] m;
    m = '0;
    for (int j = 0; j < 16; j++) m[4*j] = c[j];
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // queue the k-th round of a run (k counted from the start of the run)
  task automatic pushRound(input bit d, input int k);
    roundExp_t e;
    e.idx   = 4'(d ? (14 - k) : k);
    e.cnst  = rcOf(d ? (14 - k) : k);
    e.first = (k == 0);
    e.last  = (k == ROUNDS - 1);
    roundQ.push_back(e);
  endtask

  // monitor: the front of the queue is the round currently on the outputs; it retires on round_step
  always @(negedge clk) begin
    roundExp_t cur;
    if (monEnable) begin
      if (rc_valid) begin
        if (roundQ.size() == 0) begin
          testCount++;
          failCount++;
          $display("[TB] FAIL unexpected round: idx %0d with empty scoreboard", round_idx);
        end else begin
          cur = roundQ[0];
          checkOutput("mon round_idx", 64'(round_idx), 64'(cur.idx));
          checkOutput("mon round_cnst", 64'(round_cnst), 64'(cur.cnst));
          checkOutput("mon rc_mask", rc_mask, expandMask(cur.cnst));
          checkOutput("mon first_round", 64'(first_round), 64'(cur.first));
          checkOutput("mon last_round", 64'(last_round), 64'(cur.last));
          if (round_step) void'(roundQ.pop_front());
        end
      end else begin
        checkOutput("idle round_cnst", 64'(round_cnst), 64'd0);
        checkOutput("idle rc_mask", rc_mask, 64'd0);
        checkOutput("idle flags", {61'd0, first_round, last_round, round_step}, 64'd0);
      end
      if (done) begin
        testCount++;
        if (pendingDone == 0) begin
          failCount++;
          $display("[TB] FAIL unexpected done: got 1, expected 0 at %0t", $time);
        end else begin
          pendingDone--;
        end
      end
    end
  end

  // one run on the CPR=4 instance; stallPct<0 selects the fixed 3-cycle stall at idx 5 cyc 2
  task automatic applyStimulus(input bit d, input int stallPct, input int abortAt, input bit strayStart);
    int  nonStall, runCycles, stalls, stallRun, nRounds;
    bit  st, finished;
    nRounds = (abortAt >= 0) ? (abortAt / CPR + 1) : ROUNDS;
    for (int k = 0; k < nRounds; k++) pushRound(d, k);
    if (abortAt < 0) pendingDone++;
    start = 1'b1;
    dec   = d;
    abort = 1'b0;
    stall = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    dec   = 1'($urandom_range(0, 1));
    stall = 1'b0;
    checkOutput("start latency busy", 64'(busy), 64'd1);
    nonStall = 0; runCycles = 0; stalls = 0; stallRun = 0; finished = 1'b0;
    for (int guard = 0; guard < 1000 && !finished; guard++) begin
      if (abortAt >= 0 && nonStall == abortAt) begin
        abort = 1'b1;
        stall = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        abort = 1'b0;
        stall = 1'b0;
        start = 1'b0;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort round_cnst", 64'(round_cnst), 64'd0);
        checkOutput("abort round_idx", 64'(round_idx), 64'd0);
        checkOutput("abort leftover rounds", 64'(roundQ.size()), 64'd1);
        if (roundQ.size() > 0) void'(roundQ.pop_front());
        return;
      end
      if (stallPct < 0) st = (nonStall == 22) && (stallRun < 3);
      else              st = ($urandom_range(0, 99) < stallPct);
      if (st) stallRun++;
      stall = st;
      if (strayStart) begin
        start = 1'($urandom_range(0, 1));
        dec   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      runCycles++;
      if (st) stalls++;
      else    nonStall++;
      if (nonStall == ROUNDS * CPR) finished = 1'b1;
      else checkOutput("run busy", 64'(busy), 64'd1);
    end
    stall = 1'b0;
    start = 1'b0;
    checkOutput("run completed in budget", 64'(finished), 64'd1);
    checkOutput("end busy", 64'(busy), 64'd0);
    checkOutput("done pulse", 64'(done), 64'd1);
    checkOutput("run length", 64'(runCycles), 64'(ROUNDS * CPR + stalls));
    if (stallPct < 0) checkOutput("stalled run length", 64'(runCycles), 64'd63);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checkOutput("idle busy", 64'(busy), 64'd0);
      checkOutput("idle done", 64'(done), 64'd0);
    end
  endtask

  // directed run on the CPR=1 instance: one cycle per round, step every cycle
  task automatic runCpr1(input bit d);
    int r;
    start1 = 1'b1;
    dec1   = d;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < ROUNDS; k++) begin
      r = d ? (14 - k) : k;
      checkOutput("cpr1 busy", 64'(busy1), 64'd1);
      checkOutput("cpr1 round_idx", 64'(idx1), 64'(r));
      checkOutput("cpr1 round_cnst", 64'(cnst1), 64'(rcOf(r)));
      checkOutput("cpr1 round_step", 64'(step1), 64'd1);
      checkOutput("cpr1 first_round", 64'(first1), 64'(k == 0));
      checkOutput("cpr1 last_round", 64'(last1), 64'(k == ROUNDS - 1));
      @(posedge clk); #1;
    end
    checkOutput("cpr1 end busy", 64'(busy1), 64'd0);
    checkOutput("cpr1 done", 64'(done1), 64'd1);
  endtask

  initial begin
    // reset state while rst_n is held low
    @(posedge clk); #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset round_idx", 64'(round_idx), 64'd0);
    checkOutput("reset round_cnst", 64'(round_cnst), 64'd0);
    checkOutput("reset rc_mask", rc_mask, 64'd0);
    rst_n = 1'b1;
    monEnable = 1'b1;
    @(posedge clk); #1;

    // forward, then reverse back-to-back on the done cycle, then the fixed stall run
    applyStimulus(1'b0, 0, -1, 1'b0);
    applyStimulus(1'b1, 0, -1, 1'b0);
    applyStimulus(1'b0, -1, -1, 1'b0);
    idleCycles(1);
    // start/dec toggling during a run must be ignored
    applyStimulus(1'b0, 20, -1, 1'b1);
    idleCycles(2);
    // abort at idx 7 cyc 0
    applyStimulus(1'b0, 0, 28, 1'b0);
    // abort and start together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort+start idle busy", 64'(busy), 64'd0);
    idleCycles(1);

    // randomized runs
    for (int n = 0; n < 6; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 30)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 59)) : -1,
                    1'($urandom_range(0, 1)));
      idleCycles(int'($urandom_range(0, 2)));
    end

    // asynchronous reset mid-run at idx 9 cyc 1
    for (int k = 0; k < 10; k++) pushRound(1'b0, k);
    start = 1'b1;
    dec   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (37) begin
      @(posedge clk); #1;
    end
    checkOutput("pre-reset round_idx", 64'(round_idx), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 64'(busy), 64'd0);
    checkOutput("async reset round_idx", 64'(round_idx), 64'd0);
    checkOutput("async reset round_cnst", 64'(round_cnst), 64'd0);
    checkOutput("async reset rc_mask", rc_mask, 64'd0);
    checkOutput("async reset done", 64'(done), 64'd0);
    checkOutput("async reset leftover rounds", 64'(roundQ.size()), 64'd1);
    if (roundQ.size() > 0) void'(roundQ.pop_front());
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 0, -1, 1'b0);
    idleCycles(1);

    // single-cycle rounds
    runCpr1(1'b0);
    runCpr1(1'b1);

    checkOutput("pending done pulses", 64'(pendingDone), 64'd0);
    checkOutput("scoreboard drained", 64'(roundQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
